// File: rtl/sram16_pkg.sv
// Shared types for the 16-bit SRAM responder: FSM states, transfer-size codes, byte-enable helper.
// Pure declarations; no timing or flow-control behaviour of its own.
package sram16_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam logic SIZ_BYTE  = 1'b0;
   localparam logic SIZ_HWORD = 1'b1;

   // Halfword writes ignore the lane bit; byte writes hit exactly one lane.
   function automatic logic [1:0] byte_en(input logic siz, input logic lane);
      if (siz == SIZ_HWORD) begin
         return 2'b11;
      end
      return lane ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/sram16_array.sv
// 2**ADDR_W x 16 storage with per-byte write enables and a registered read port.
// Read data appears the edge after rd_en_i; no backpressure, the caller sequences accesses.
module sram16_array #(
   parameter int ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic [ADDR_W-1:0] idx_i,
   input  logic [1:0]        be_i,
   input  logic [15:0]       wdat_i,
   input  logic              rd_en_i,
   output logic [15:0]       rdat_o
);

   logic [15:0] mem_q [2**ADDR_W];
   logic [15:0] rdat_q, rdat_d;

   // Contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (be_i[0]) begin
         mem_q[idx_i][7:0] <= wdat_i[7:0];
      end
      if (be_i[1]) begin
         mem_q[idx_i][15:8] <= wdat_i[15:8];
      end
   end

   always_comb begin
      rdat_d = rdat_q;
      if (rd_en_i) begin
         rdat_d = mem_q[idx_i];
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rdat_q <= 16'h0000;
      end else begin
         rdat_q <= rdat_d;
      end
   end

   assign rdat_o = rdat_q;

endmodule

// File: rtl/sram16_responder.sv
// 16-bit bus SRAM responder; WAIT state and counter exist only with SRAM16_RESPONDER_WAIT_EN.
// ack_o rises WAIT_CYCLES+1 edges after start (1 without the macro) and is held while cyc&stb stay high.
module sram16_responder
   import sram16_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic [63:0] adr_i,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic        siz_i,
   input  logic        signed_i,
   input  logic [15:0] dat_i,
   output logic        ack_o,
   output logic [15:0] dat_o
);

   localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

   state_t          state_q, state_d;
   logic            run_q;
   logic            req;
   logic            enter_ack;
   logic [ADDR_W:0] cur_adr;
   logic            cur_we;
   logic            cur_siz;
   logic [15:0]     cur_dat;
   logic            fmt_byte_q, fmt_byte_d;
   logic            fmt_lane_q, fmt_lane_d;
   logic [1:0]      mem_be;
   logic            mem_rd_en;
   logic [15:0]     mem_wdat;
   logic [15:0]     mem_rdat;
   logic            unused_ok;

   assign req = cyc_i & stb_i;

`ifdef SRAM16_RESPONDER_WAIT_EN
   logic [3:0]      cnt_q, cnt_d;
   logic [ADDR_W:0] adr_q, adr_d;
   logic            we_q, we_d;
   logic            siz_q, siz_d;
   logic [15:0]     wdat_q, wdat_d;

   // A zero-wait transfer enters ACK on its starting edge, so it must use the live inputs.
   assign cur_adr = (state_q == IDLE) ? adr_i[ADDR_W:0] : adr_q;
   assign cur_we  = (state_q == IDLE) ? we_i  : we_q;
   assign cur_siz = (state_q == IDLE) ? siz_i : siz_q;
   assign cur_dat = (state_q == IDLE) ? dat_i : wdat_q;
   assign unused_ok = ^{signed_i, adr_i[63:ADDR_W+1]};
`else
   assign cur_adr = adr_i[ADDR_W:0];
   assign cur_we  = we_i;
   assign cur_siz = siz_i;
   assign cur_dat = dat_i;
   assign unused_ok = ^{signed_i, adr_i[63:ADDR_W+1], WAIT_N};
`endif

   always_comb begin
      state_d   = state_q;
      enter_ack = 1'b0;
`ifdef SRAM16_RESPONDER_WAIT_EN
      cnt_d  = cnt_q;
      adr_d  = adr_q;
      we_d   = we_q;
      siz_d  = siz_q;
      wdat_d = wdat_q;
`endif
      case (state_q)
         IDLE: begin
            if (req && run_q) begin
`ifdef SRAM16_RESPONDER_WAIT_EN
               adr_d  = adr_i[ADDR_W:0];
               we_d   = we_i;
               siz_d  = siz_i;
               wdat_d = dat_i;
               if (WAIT_N != 4'd0) begin
                  state_d = WAIT;
                  cnt_d   = WAIT_N;
               end else begin
                  state_d   = ACK;
                  enter_ack = 1'b1;
               end
`else
               state_d   = ACK;
               enter_ack = 1'b1;
`endif
            end
         end
`ifdef SRAM16_RESPONDER_WAIT_EN
         WAIT: begin
            if (!req) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd1) begin
               state_d   = ACK;
               cnt_d     = 4'd0;
               enter_ack = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
`endif
         ACK: begin
            if (!req) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Write and read each happen once, on the ACK entry edge only.
   always_comb begin
      mem_be     = 2'b00;
      mem_rd_en  = 1'b0;
      mem_wdat   = (cur_siz == SIZ_HWORD) ? cur_dat : {cur_dat[7:0], cur_dat[7:0]};
      fmt_byte_d = fmt_byte_q;
      fmt_lane_d = fmt_lane_q;
      if (enter_ack) begin
         if (cur_we) begin
            mem_be = byte_en(cur_siz, cur_adr[0]);
         end else begin
            mem_rd_en  = 1'b1;
            fmt_byte_d = (cur_siz == SIZ_BYTE);
            fmt_lane_d = cur_adr[0];
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= IDLE;
         run_q      <= 1'b0;
         fmt_byte_q <= 1'b0;
         fmt_lane_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         run_q      <= 1'b1;
         fmt_byte_q <= fmt_byte_d;
         fmt_lane_q <= fmt_lane_d;
      end
   end

`ifdef SRAM16_RESPONDER_WAIT_EN
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cnt_q  <= 4'd0;
         adr_q  <= '0;
         we_q   <= 1'b0;
         siz_q  <= 1'b0;
         wdat_q <= 16'h0000;
      end else begin
         cnt_q  <= cnt_d;
         adr_q  <= adr_d;
         we_q   <= we_d;
         siz_q  <= siz_d;
         wdat_q <= wdat_d;
      end
   end
`endif

   sram16_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .idx_i    (cur_adr[ADDR_W:1]),
      .be_i     (mem_be),
      .wdat_i   (mem_wdat),
      .rd_en_i  (mem_rd_en),
      .rdat_o   (mem_rdat)
   );

   assign ack_o = (state_q == ACK);
   assign dat_o = fmt_byte_q ? {8'h00, (fmt_lane_q ? mem_rdat[15:8] : mem_rdat[7:0])} : mem_rdat;

endmodule

// File: tb/tb_sram16_responder.sv
// Directed self-checking bench for sram16_responder (ADDR_W=10, WAIT_CYCLES=3).
module tb_sram16_responder;
   import sram16_pkg::*;

`ifdef SRAM16_RESPONDER_WAIT_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 1;
`endif

   logic        clk_i = 1'b0;
   logic        reset_ni;
   logic [63:0] adr_i;
   logic        cyc_i, stb_i, we_i, siz_i, signed_i;
   logic [15:0] dat_i;
   logic        ack_o;
   logic [15:0] dat_o;

   int          total = 0;
   int          bad = 0;
   int          lat;
   logic [15:0] rd;

   sram16_responder #(
      .ADDR_W      (10),
      .WAIT_CYCLES (3)
   ) dut (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .adr_i    (adr_i),
      .cyc_i    (cyc_i),
      .stb_i    (stb_i),
      .we_i     (we_i),
      .siz_i    (siz_i),
      .signed_i (signed_i),
      .dat_i    (dat_i),
      .ack_o    (ack_o),
      .dat_o    (dat_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Starts a transfer, scrambles the request fields after each edge, returns edges to ack.
   task automatic xfer(input logic we, input logic siz, input logic [63:0] adr,
                       input logic [15:0] dat, output int n, output logic [15:0] rdat);
      adr_i = adr; we_i = we; siz_i = siz; dat_i = dat;
      cyc_i = 1'b1; stb_i = 1'b1;
      n = 0;
      while (n < 40) begin
         @(posedge clk_i); #1;
         n++;
         adr_i = ~adr; dat_i = ~dat; we_i = ~we; siz_i = ~siz;
         if (ack_o) break;
      end
      rdat = dat_o;
   endtask

   task automatic end_xfer();
      cyc_i = 1'b0; stb_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   initial begin
      reset_ni = 1'b0; adr_i = '0; cyc_i = 1'b0; stb_i = 1'b0;
      we_i = 1'b0; siz_i = 1'b0; signed_i = 1'b1; dat_i = '0;
      #3;
      chk("reset ack", 32'(ack_o), 32'd0);
      chk("reset dat", 32'(dat_o), 32'd0);
      repeat (2) @(posedge clk_i);
      #1 reset_ni = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;

      xfer(1'b1, SIZ_HWORD, 64'hFFFF_0000_0000_1112, 16'hAA55, lat, rd);
      chk("hw wr latency", 32'(lat), 32'(LAT));
      end_xfer();
      chk("hw wr ack drop", 32'(ack_o), 32'd0);
      xfer(1'b0, SIZ_HWORD, 64'h0000_0000_0000_1112, 16'h0000, lat, rd);
      chk("hw rd latency", 32'(lat), 32'(LAT));
      chk("hw rd 1112", 32'(rd), 32'h0000AA55);
      end_xfer();
      chk("hw rd ack drop", 32'(ack_o), 32'd0);
      chk("dat held idle", 32'(dat_o), 32'h0000AA55);

      xfer(1'b1, SIZ_HWORD, 64'h1234_0000_0000_1110, 16'hAA55, lat, rd);
      end_xfer();
      xfer(1'b1, SIZ_BYTE, 64'h8000_0000_0000_1111, 16'hFFDD, lat, rd);
      chk("byte wr latency", 32'(lat), 32'(LAT));
      end_xfer();
      xfer(1'b0, SIZ_HWORD, 64'h0000_0000_0000_1110, 16'h0000, lat, rd);
      chk("hw rd 1110", 32'(rd), 32'h0000DD55);
      end_xfer();
      xfer(1'b0, SIZ_BYTE, 64'h0000_0000_0000_1111, 16'h0000, lat, rd);
      chk("byte rd 1111", 32'(rd), 32'h000000DD);
      end_xfer();
      xfer(1'b0, SIZ_BYTE, 64'h0000_0000_0000_1110, 16'h0000, lat, rd);
      chk("byte rd 1110", 32'(rd), 32'h00000055);
      end_xfer();
      xfer(1'b0, SIZ_HWORD, 64'h0000_0000_0000_1112, 16'h0000, lat, rd);
      chk("neighbour intact", 32'(rd), 32'h0000AA55);
      end_xfer();

      // Byte write held in ACK for 5 cycles while the request fields wander.
      xfer(1'b1, SIZ_BYTE, 64'h0000_0000_0000_1113, 16'h0011, lat, rd);
      chk("hold wr latency", 32'(lat), 32'(LAT));
      adr_i = 64'h0000_0000_0000_1110; dat_i = 16'h7777; we_i = 1'b1; siz_i = SIZ_HWORD;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i); #1;
         chk($sformatf("hold ack %0d", i), 32'(ack_o), 32'd1);
      end
      end_xfer();
      chk("hold ack drop", 32'(ack_o), 32'd0);
      xfer(1'b0, SIZ_HWORD, 64'h0000_0000_0000_1112, 16'h0000, lat, rd);
      chk("hold wr result", 32'(rd), 32'h00001155);
      end_xfer();
      xfer(1'b0, SIZ_HWORD, 64'h0000_0000_0000_1110, 16'h0000, lat, rd);
      chk("hold no rewrite", 32'(rd), 32'h0000DD55);
      end_xfer();

`ifdef SRAM16_RESPONDER_WAIT_EN
      // Abort in the second wait cycle: no ack, no write.
      adr_i = 64'h0000_0000_0000_1112; we_i = 1'b1; siz_i = SIZ_HWORD; dat_i = 16'hBEEF;
      cyc_i = 1'b1; stb_i = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk_i); #1;
         chk($sformatf("abort ack edge %0d", i), 32'(ack_o), 32'd0);
         if (i == 2) cyc_i = 1'b0;
      end
      stb_i = 1'b0;
`else
      // Strobe without cycle must never start a transfer.
      adr_i = 64'h0000_0000_0000_1112; we_i = 1'b1; siz_i = SIZ_HWORD; dat_i = 16'hBEEF;
      cyc_i = 1'b0; stb_i = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk_i); #1;
         chk($sformatf("no cyc ack edge %0d", i), 32'(ack_o), 32'd0);
      end
      stb_i = 1'b0;
`endif
      @(posedge clk_i); #1;
      xfer(1'b0, SIZ_HWORD, 64'h0000_0000_0000_1112, 16'h0000, lat, rd);
      chk("old data kept", 32'(rd), 32'h00001155);

      // Reset pulsed while ack is high.
      #2 reset_ni = 1'b0;
      #1;
      chk("async rst ack", 32'(ack_o), 32'd0);
      chk("async rst dat", 32'(dat_o), 32'd0);
      cyc_i = 1'b0; stb_i = 1'b0;
      @(posedge clk_i); #1;
      reset_ni = 1'b1;
      chk("post rst idle", 32'(ack_o), 32'd0);
      repeat (2) @(posedge clk_i);
      #1;

      xfer(1'b1, SIZ_HWORD, 64'h0000_0000_0000_0002, 16'h1234, lat, rd);
      chk("post rst latency", 32'(lat), 32'(LAT));
      end_xfer();
      xfer(1'b0, SIZ_HWORD, 64'h0000_0000_0000_0802, 16'h0000, lat, rd);
      chk("alias 0802", 32'(rd), 32'h00001234);
      end_xfer();
      xfer(1'b0, SIZ_HWORD, 64'h0000_0000_0000_1112, 16'h0000, lat, rd);
      chk("storage survives rst", 32'(rd), 32'h00001155);
      end_xfer();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram16_responder.md
SRAM16_RESPONDER -- requirements
Module: sram16_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, halfword-address width (storage depth 2**ADDR_W x 16 bits).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted per transfer (legal range 0..15).
REQ-003 SHALL have port clk_i  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_ni  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port adr_i  in  64  byte address from the 16-bit bus initiator.
REQ-006 SHALL have port cyc_i  in  1  bus cycle in progress.
REQ-007 SHALL have port stb_i  in  1  transfer strobe.
REQ-008 SHALL have port we_i  in  1  1 = write, 0 = read.
REQ-009 SHALL have port siz_i  in  1  0 = byte, 1 = halfword.
REQ-010 SHALL have port signed_i  in  1  accepted and ignored; the initiator performs sign extension.
REQ-011 SHALL have port dat_i  in  16  write data; bytes are carried in dat_i[7:0].
REQ-012 SHALL have port ack_o  out  1  transfer acknowledge.
REQ-013 SHALL have port dat_o  out  16  read data; bytes are returned in dat_o[7:0] with dat_o[15:8] = 0.

Function
REQ-014 SHALL implement states IDLE, WAIT and ACK.
REQ-015 SHALL start a transfer when cyc_i & stb_i is sampled high in IDLE, and latch adr_i, we_i, siz_i and dat_i on that edge.
REQ-016 SHALL go IDLE->WAIT when WAIT_CYCLES > 0, or IDLE->ACK when WAIT_CYCLES = 0.
REQ-017 SHALL stay in WAIT for exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter, then go to ACK.
REQ-018 SHALL assert ack_o first WAIT_CYCLES+1 rising edges after the starting edge (latency 1 when there are no waits).
REQ-019 SHALL hold ack_o = 1 and dat_o stable in ACK while cyc_i & stb_i remain high, and return to IDLE on the edge where either is sampled low, with ack_o = 0 from that edge.
REQ-020 SHALL perform the write exactly once, on the edge entering ACK; holding stb_i in ACK causes no further writes.
REQ-021 SHALL use word index = adr_i[ADDR_W:1]; higher address bits are ignored, so addresses wrap and alias modulo 2**(ADDR_W+1) bytes.
REQ-022 SHALL use little-endian byte lanes: adr_i[0]=0 selects word bits [7:0], adr_i[0]=1 selects word bits [15:8].
REQ-023 SHALL, for a byte write, update only the selected byte from dat_i[7:0]; the other byte is unchanged.
REQ-024 SHALL, for a halfword write, write dat_i[15:0] to the whole word; adr_i[0] is ignored (alignment is the initiator's job).
REQ-025 SHALL, for a byte read, present the selected byte in dat_o[7:0] with zero in [15:8]; a halfword read presents the full word.
REQ-026 SHALL register dat_o on the edge entering ACK; dat_o keeps its last value outside ACK.
REQ-027 SHALL abort if cyc_i or stb_i drops while in WAIT: return to IDLE, perform no write, and never assert ack_o.
REQ-028 SHALL ignore changes on adr_i, we_i, siz_i and dat_i after the starting edge.

Reset
REQ-029 SHALL, while reset_ni = 0, force the state to IDLE and ack_o, dat_o and the wait counter to 0, asynchronously.
REQ-030 SHALL discard a transfer interrupted by reset before ACK entry, with no write; storage contents are not reset.
REQ-031 SHALL recognise a new transfer no earlier than the first rising edge after reset_ni rises.

Configuration
REQ-032 SHALL, with SRAM16_RESPONDER_WAIT_EN defined, include the WAIT state and counter, with behaviour per REQ-016..018.
REQ-033 SHALL, without SRAM16_RESPONDER_WAIT_EN, omit the WAIT state and counter, ignore WAIT_CYCLES, and always go IDLE->ACK (latency 1).

Structure
REQ-034 SHALL place the state enum and the siz encoding constants (SIZ_BYTE = 0, SIZ_HWORD = 1) in shared package sram16_pkg.
REQ-035 SHALL keep storage in sub-module sram16_array: 2**ADDR_W x 16 with two byte-write enables, registered read.

Verification
REQ-036 SHALL cover, with no macro: halfword write 0xAA55 at adr 0x...1112, then halfword read there -> ack_o on the 1st edge after stb, dat_o = 0xAA55.
REQ-037 SHALL cover, with no macro: byte write 0xDD at adr 0x...1111 over word 0xAA55 -> halfword read at 0x...1110 returns 0xDD55; byte read at 0x...1111 returns 0x00DD.
REQ-038 SHALL cover, with the macro and WAIT_CYCLES = 3: read -> ack_o is 0 for edges 1-3 and 1 at edge 4; ack_o drops on the edge where stb is low.
REQ-039 SHALL cover stb held high for 5 cycles in ACK after a byte write of 0x11 -> exactly one write, ack_o held high, then IDLE.
REQ-040 SHALL cover, with WAIT_CYCLES = 3, cyc dropped in cycle 2 of a write of 0xBEEF -> no ack, and a later read returns the old data.
REQ-041 SHALL cover reset_ni pulsed low during ACK -> ack_o = 0 immediately (asynchronous), state IDLE; adr 0x...0002 and 0x...0802 alias when ADDR_W = 10.
